// File: rtl/planificador_ascensor.sv
// Request scheduler and motion sequencer for a 4-floor elevator.
// Latches car/hall calls, serves them with a collective up/down sweep, and times travel and door dwell.
module planificador_ascensor #(
  parameter int TICK_DIV     = 100000000,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] car_btn,
  input  logic [2:0] hall_up,
  input  logic [2:0] hall_dn,
  output logic [1:0] piso,
  output logic [1:0] accion,
  output logic       puertas,
  output logic [3:0] pending
);
  localparam int DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  function automatic logic [3:0] onehot(input logic [1:0] p);
    onehot = 4'b0001 << p;
  endfunction

  function automatic logic [3:0] above_of(input logic [1:0] p);
    above_of = 4'b1110 << p;
  endfunction

  function automatic logic [3:0] below_of(input logic [1:0] p);
    below_of = ~(4'b1111 << p);
  endfunction

  function automatic logic ahead_of(input logic [1:0] p, input logic up, input logic [3:0] r);
    ahead_of = |(r & (up ? above_of(p) : below_of(p)));
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         piso_q, piso_d;
  logic               sweep_q, sweep_d;  // 1 = up
  logic [1:0]         accion_q, accion_d;
  logic               puertas_q, puertas_d;
  logic [3:0]         pending_q;
  // Hall requests kept 4 wide by floor; up_q[3] and dn_q[0] never set.
  logic [3:0]         car_q, car_d, up_q, up_d, dn_q, dn_d;
  logic               sup_up_q, sup_up_d, sup_dn_q, sup_dn_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0] here, req_all, btn_up, btn_dn;
  logic [3:0] supp_car, supp_up, supp_dn;
  logic [3:0] clr_car, clr_up, clr_dn, at_floor;
  logic       in_door, restart, tick;
  logic       enter_door, clear_all, tmr_rst, open_both;

  assign here    = onehot(piso_q);
  assign req_all = car_q | up_q | dn_q;
  assign btn_up  = {1'b0, hall_up};
  assign btn_dn  = {hall_dn, 1'b0};
  assign tick    = (div_q == DIV_W'(TICK_DIV - 1));

  // While doors are open, presses for calls being served just hold the doors.
  assign in_door  = (state_q == DOOR);
  assign supp_car = in_door ? here : 4'b0000;
  assign supp_up  = (in_door && sup_up_q) ? here : 4'b0000;
  assign supp_dn  = (in_door && sup_dn_q) ? here : 4'b0000;
  assign restart  = |((car_btn & supp_car) | (btn_up & supp_up) | (btn_dn & supp_dn));

  always_comb begin
    state_d    = state_q;
    piso_d     = piso_q;
    sweep_d    = sweep_q;
    sup_up_d   = sup_up_q;
    sup_dn_d   = sup_dn_q;
    enter_door = 1'b0;
    clear_all  = 1'b0;
    tmr_rst    = 1'b0;
    open_both  = 1'b0;
    at_floor   = 4'b0000;
    clr_car    = 4'b0000;
    clr_up     = 4'b0000;
    clr_dn     = 4'b0000;
    case (state_q)
      IDLE: begin
        tmr_rst = 1'b1;
        if (|(req_all & here)) begin
          enter_door = 1'b1;
          clear_all  = 1'b1;
        end else if (|(req_all & above_of(piso_q))) begin
          state_d = MOVE;
          sweep_d = 1'b1;
        end else if (|req_all) begin
          state_d = MOVE;
          sweep_d = 1'b0;
        end
      end
      MOVE: begin
        if (tick && cnt_q == CNT_W'(TRAVEL_TICKS - 1)) begin
          tmr_rst  = 1'b1;
          piso_d   = sweep_q ? piso_q + 2'd1 : piso_q - 2'd1;
          at_floor = onehot(piso_d);
          if (|(at_floor & (car_q | (sweep_q ? up_q : dn_q))) ||
              (!ahead_of(piso_d, sweep_q, req_all) && |(at_floor & req_all)))
            enter_door = 1'b1;
        end
      end
      DOOR: begin
        if (restart) begin
          tmr_rst = 1'b1;
        end else if (tick && cnt_q == CNT_W'(DOOR_TICKS - 1)) begin
          tmr_rst = 1'b1;
          if (ahead_of(piso_q, sweep_q, req_all)) begin
            state_d = MOVE;
          end else if (ahead_of(piso_q, ~sweep_q, req_all)) begin
            state_d = MOVE;
            sweep_d = ~sweep_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tmr_rst = 1'b1;
      end
    endcase

    // Door opening: serve this floor; reverse the sweep when nothing lies beyond.
    if (enter_door) begin
      at_floor  = onehot(piso_d);
      open_both = clear_all || !ahead_of(piso_d, sweep_q, req_all);
      state_d   = DOOR;
      tmr_rst   = 1'b1;
      clr_car   = at_floor;
      clr_up    = (open_both || sweep_q) ? at_floor : 4'b0000;
      clr_dn    = (open_both || !sweep_q) ? at_floor : 4'b0000;
      sup_up_d  = open_both || sweep_q;
      sup_dn_d  = open_both || !sweep_q;
      if (!ahead_of(piso_d, sweep_q, req_all))
        sweep_d = ~sweep_q;
    end
  end

  assign car_d     = (car_q | (car_btn & ~supp_car)) & ~clr_car;
  assign up_d      = (up_q  | (btn_up  & ~supp_up))  & ~clr_up;
  assign dn_d      = (dn_q  | (btn_dn  & ~supp_dn))  & ~clr_dn;
  assign accion_d  = (state_d == MOVE) ? (sweep_d ? 2'd1 : 2'd2) : 2'd0;
  assign puertas_d = (state_d == DOOR);

  always_comb begin
    div_d = div_q + DIV_W'(1);
    cnt_d = cnt_q;
    if (tmr_rst) begin
      div_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      div_d = '0;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      piso_q    <= 2'd0;
      sweep_q   <= 1'b1;
      accion_q  <= 2'd0;
      puertas_q <= 1'b0;
      pending_q <= 4'b0000;
      car_q     <= 4'b0000;
      up_q      <= 4'b0000;
      dn_q      <= 4'b0000;
      sup_up_q  <= 1'b0;
      sup_dn_q  <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      piso_q    <= piso_d;
      sweep_q   <= sweep_d;
      accion_q  <= accion_d;
      puertas_q <= puertas_d;
      pending_q <= car_d | up_d | dn_d;
      car_q     <= car_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      sup_up_q  <= sup_up_d;
      sup_dn_q  <= sup_dn_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
    end
  end

  assign piso    = piso_q;
  assign accion  = accion_q;
  assign puertas = puertas_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_planificador_ascensor.sv
// Bench for planificador_ascensor: directed elevator scenarios and random calls,
// each cycle compared against a behavioural model of the sweep rules.
module tb_planificador_ascensor;
  localparam int TD = 4, TT = 3, DT = 2;
  localparam int STEP = TT * TD, DWELL = DT * TD;

  logic       clk, rst;
  logic [3:0] car_btn;
  logic [2:0] hall_up, hall_dn;
  logic [1:0] piso, accion;
  logic       puertas;
  logic [3:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 moving, 2 doors open; dir +1/-1; timer counts cycles left.
  int m_mode, m_floor, m_dir, m_timer;
  bit m_car[4], m_up[4], m_dn[4];
  bit o_car[4], o_up[4], o_dn[4];
  bit m_sup_up, m_sup_dn;

  planificador_ascensor #(.TICK_DIV(TD), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .car_btn(car_btn), .hall_up(hall_up), .hall_dn(hall_dn),
    .piso(piso), .accion(accion), .puertas(puertas), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit old_any(int f);
    return o_car[f] | o_up[f] | o_dn[f];
  endfunction

  function automatic bit old_ahead(int f, int d);
    for (int g = 0; g < 4; g++)
      if ((g - f) * d > 0 && old_any(g)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] model_out();
    logic [3:0] p;
    logic [1:0] a;
    for (int f = 0; f < 4; f++) p[f] = m_car[f] | m_up[f] | m_dn[f];
    a = (m_mode == 1) ? ((m_dir > 0) ? 2'd1 : 2'd2) : 2'd0;
    return {2'(m_floor), a, (m_mode == 2), p};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_floor = 0; m_dir = 1; m_timer = 0;
    m_sup_up = 0; m_sup_dn = 0;
    for (int f = 0; f < 4; f++) begin
      m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0;
    end
  endtask

  task automatic enter_door(input bit all);
    bit beyond, both;
    beyond = old_ahead(m_floor, m_dir);
    both = all || !beyond;
    m_mode = 2;
    m_timer = DWELL;
    m_car[m_floor] = 0;
    if (both || m_dir > 0) m_up[m_floor] = 0;
    if (both || m_dir < 0) m_dn[m_floor] = 0;
    m_sup_up = both || m_dir > 0;
    m_sup_dn = both || m_dir < 0;
    if (!beyond) m_dir = -m_dir;
  endtask

  task automatic model_edge(input logic [3:0] cb, input logic [2:0] hu, input logic [2:0] hd);
    bit restart, at_door, stop;
    restart = 0;
    o_car = m_car; o_up = m_up; o_dn = m_dn;
    for (int f = 0; f < 4; f++) begin
      at_door = (m_mode == 2) && (f == m_floor);
      if (cb[f]) begin
        if (at_door) restart = 1; else m_car[f] = 1;
      end
      if (f < 3) if (hu[f]) begin
        if (at_door && m_sup_up) restart = 1; else m_up[f] = 1;
      end
      if (f > 0) if (hd[f-1]) begin
        if (at_door && m_sup_dn) restart = 1; else m_dn[f] = 1;
      end
    end
    case (m_mode)
      0: begin
        if (old_any(m_floor)) enter_door(1);
        else if (old_ahead(m_floor, 1)) begin m_dir = 1; m_mode = 1; m_timer = STEP; end
        else if (old_ahead(m_floor, -1)) begin m_dir = -1; m_mode = 1; m_timer = STEP; end
      end
      1: begin
        m_timer--;
        if (m_timer == 0) begin
          m_floor += m_dir;
          stop = o_car[m_floor] || ((m_dir > 0) ? o_up[m_floor] : o_dn[m_floor]) ||
                 (!old_ahead(m_floor, m_dir) && old_any(m_floor));
          if (stop) enter_door(0); else m_timer = STEP;
        end
      end
      default: begin
        if (restart) m_timer = DWELL;
        else begin
          m_timer--;
          if (m_timer == 0) begin
            if (old_ahead(m_floor, m_dir)) begin m_mode = 1; m_timer = STEP; end
            else if (old_ahead(m_floor, -m_dir)) begin m_dir = -m_dir; m_mode = 1; m_timer = STEP; end
            else m_mode = 0;
          end
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] cb, input logic [2:0] hu, input logic [2:0] hd, input logic r);
    car_btn = cb; hall_up = hu; hall_dn = hd; rst = r;
    @(posedge clk);
    if (r) model_reset(); else model_edge(cb, hu, hd);
    #1;
    chk("cycle {piso,accion,puertas,pending}", int'({piso, accion, puertas, pending}), int'(model_out()));
  endtask

  task automatic step(input logic [3:0] cb, input logic [2:0] hu, input logic [2:0] hd);
    cyc(cb, hu, hd, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 3'b0, 3'b0);
  endtask

  initial begin
    int open_cnt;
    car_btn = 0; hall_up = 0; hall_dn = 0; rst = 1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("reset_outputs", int'({piso, accion, puertas, pending}), 0);

    $display("[TB] press at current floor");
    step(4'b0001, 0, 0);
    chk("press_latched", pending, 4'b0001);
    open_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      if (puertas) open_cnt++;
      chk("press_pending", pending, 0);
    end
    chk("dwell_cycles", open_cnt, DWELL);

    $display("[TB] full run 0 -> 3");
    step(4'b1000, 0, 0);
    step(0, 0, 0);
    chk("run_accion", accion, 1);
    run(STEP);     chk("run_piso1", piso, 1);
    run(STEP);     chk("run_piso2", piso, 2);
    run(STEP);     chk("run_piso3", piso, 3);
    chk("run_stop", int'({accion, puertas}), 3'b001);
    chk("run_pending3", pending[3], 0);
    run(DWELL);    chk("run_idle", int'({accion, puertas}), 0);

    $display("[TB] collective sweep");
    cyc(0, 0, 0, 1);
    step(4'b1000, 0, 0);
    step(0, 0, 0);
    step(0, 3'b010, 3'b010);
    run(STEP - 1); chk("sweep_stop1", int'({piso, puertas}), 3'b011);
    chk("sweep_pend1", pending, 4'b1100);
    run(DWELL);    chk("sweep_leave1", accion, 1);
    run(STEP);     chk("sweep_pass2", int'({piso, accion, puertas}), 5'b10010);
    run(STEP);     chk("sweep_stop3", int'({piso, puertas}), 3'b111);
    chk("sweep_pend3", pending, 4'b0100);
    run(DWELL);    chk("sweep_down", accion, 2);
    run(STEP);     chk("sweep_stop2", int'({piso, puertas, pending}), 7'b1010000);
    run(DWELL);

    $display("[TB] simultaneous calls from floor 2");
    step(4'b1001, 0, 0);
    step(0, 0, 0);
    chk("simul_up_first", accion, 1);
    run(STEP);     chk("simul_at3", int'({piso, puertas}), 3'b111);
    run(DWELL);    chk("simul_desc_acc", accion, 2);
    chk("simul_desc_pend", pending, 4'b0001);
    run(STEP);     chk("simul_pend_p2", pending, 4'b0001);
    run(STEP);     chk("simul_pend_p1", int'({piso, pending}), 6'b010001);
    run(STEP);     chk("simul_at0", int'({piso, puertas, pending}), 7'b0010000);
    run(DWELL);

    $display("[TB] door restart at floor 1");
    step(4'b0010, 0, 0);
    step(0, 0, 0);
    run(STEP);     chk("restart_open", int'({piso, puertas}), 3'b011);
    run(5);
    step(4'b0010, 0, 0);
    chk("restart_pend", pending[1], 0);
    run(7);        chk("restart_still_open", int'({puertas, pending}), 5'b10000);
    run(1);        chk("restart_closed", puertas, 0);

    $display("[TB] reset during descent");
    step(4'b1000, 0, 0);
    step(0, 0, 0);
    run(2 * STEP); chk("rst_at3", int'({piso, puertas}), 3'b111);
    step(4'b0001, 0, 0);
    run(DWELL - 1);
    run(STEP);     chk("rst_moving", int'({piso, accion}), 4'b1010);
    cyc(0, 0, 0, 1);
    chk("rst_cleared", int'({piso, accion, puertas, pending}), 0);

    $display("[TB] random calls");
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] cb;
      logic [2:0] hu, hd;
      for (int b = 0; b < 4; b++) cb[b] = ($urandom_range(0, 24) == 0);
      for (int b = 0; b < 3; b++) hu[b] = ($urandom_range(0, 30) == 0);
      for (int b = 0; b < 3; b++) hd[b] = ($urandom_range(0, 30) == 0);
      cyc(cb, hu, hd, $urandom_range(0, 700) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/planificador_ascensor.md
# planificador_ascensor

Request scheduler and motion sequencer for the 4-floor elevator. It latches car and hall calls and picks the next floor with a collective up/down sweep. It times floor-to-floor travel and door dwell from the system clock. It drives the `piso`/`accion`/`puertas` encoding consumed by the display path (`acciones_to_bcd`).

## Interface
- `TICK_DIV`, default 100000000: clk cycles per timing tick (1 s at 100 MHz).
- `TRAVEL_TICKS`, default 2: ticks to move one floor.
- `DOOR_TICKS`, default 3: ticks doors stay open.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `car_btn` input, 4 bits: car panel buttons; bit i means go to floor i. Level-sampled.
- `hall_up` input, 3 bits: up-call buttons; bit i means floor i (floors 0..2).
- `hall_dn` input, 3 bits: down-call buttons; bit i means floor i+1 (floors 1..3).
- `piso` output, 2 bits: current floor, 0..3.
- `accion` output, 2 bits: 0 stopped, 1 moving up, 2 moving down.
- `puertas` output, 1 bit: 1 doors open.
- `pending` output, 4 bits: bit f is the OR of all latched requests at floor f.

## Operation
- Request registers are `car_req[3:0]`, `up_req[2:0]` and `dn_req[3:1]`. Any button sampled high at a clk edge sets its bit. A bit is cleared only as listed below.
- Internal `sweep` register holds the preferred direction (up or down). Reset value is up.
- "Ahead" means any request bit at a floor strictly beyond `piso` in the `sweep` direction. "Behind" means the same in the opposite direction.
- IDLE (`accion`=0, `puertas`=0):
  - No request pending: stay in IDLE.
  - Request at `piso`: go to DOOR. Clear `car_req`, `up_req` and `dn_req` at `piso`.
  - Otherwise, any request above `piso`: set `sweep` to up and go to MOVE. Up is checked before down.
  - Otherwise: set `sweep` to down and go to MOVE.
- MOVE (`accion` = 1 when `sweep` is up, 2 when down):
  - After TRAVEL_TICKS ticks, `piso` steps by ±1.
  - Stop condition at the new floor: `car_req[piso]`, or the hall call in the `sweep` direction at `piso`, or (nothing ahead and any request at `piso`).
  - On stop: go to DOOR.
  - Otherwise: stay in MOVE and restart the travel timer.
- DOOR entry clearing:
  - Always clear `car_req[piso]` and the `sweep`-direction hall bit at `piso`.
  - If nothing is ahead, also clear the opposite hall bit at `piso` and flip `sweep`.
- DOOR (`puertas`=1, `accion`=0):
  - A press of `car_btn[piso]`, or of a hall button at `piso` whose request bit DOOR entry would clear, is not latched. It restarts the door timer.
  - After DOOR_TICKS ticks:
    - Anything ahead: MOVE in `sweep`.
    - Else anything behind: flip `sweep`, then MOVE.
    - Else: IDLE.
- Travel is not interruptible. `piso` never leaves 0..3, and MOVE never starts toward a floor with no request.
- Reset mid-operation: all state is discarded. The car is considered at floor 0 (there is no position sensor).

## Timing
- Reset values: `piso`=0, `accion`=0, `puertas`=0, `pending`=0, state IDLE, `sweep` up, all counters 0.
- A button sampled at edge N sets its request bit, visible in cycle N+1.
- In IDLE, the state change happens at edge N+1, so outputs change in cycle N+2.
- Tick divider: counts 0..TICK_DIV-1 and pulses a tick on wrap. It restarts to 0 on every state transition, every MOVE floor step and every door restart.
- A floor step occurs exactly TRAVEL_TICKS*TICK_DIV cycles after MOVE entry or the previous step.
- DOOR lasts exactly DOOR_TICKS*TICK_DIV cycles after entry or the last restart.
- The DOOR exit decision and the arrival stop decision use request registers as of the deciding edge. A press on that same edge counts for the next decision only.
- `pending` is registered and reflects set/clear one cycle after the edge.

## Test plan
Bench parameters: TICK_DIV=4, TRAVEL_TICKS=3, DOOR_TICKS=2. One floor step is 12 cycles; door dwell is 8 cycles.
- Press at current floor: after reset, pulse `car_btn[0]` one cycle -> `puertas`=1 from cycle +2 for exactly 8 cycles, `accion`=0, `pending`=0 throughout; then IDLE.
- Full run: IDLE at floor 0, pulse `car_btn[3]` -> `accion`=1; `piso` = 1, 2, 3 at +12, +24, +36 cycles; then `accion`=0, `puertas`=1 for 8 cycles; `pending[3]` falls at the stop.
- Collective sweep: moving up toward floor 3, latch `hall_up[1]` and `hall_dn[1]` (floor 2) before arrival at floor 1 -> stop at floor 1 and clear `up_req[1]`; pass floor 2; stop at 3; return down and stop at 2.
- Simultaneous calls: IDLE at floor 2, `car_btn[0]` and `car_btn[3]` on the same cycle -> `accion`=1 first; serve 3; then down to 0 with `pending` = 4'b0001 during the descent.
- Door restart: during DOOR at floor 1, press `car_btn[1]` at dwell cycle 6 -> doors stay open 8 more cycles, `pending[1]` stays 0.
- Reset mid-MOVE: assert `rst` one cycle while `piso`=2 and `accion`=2 -> next cycle `piso`=0, `accion`=0, `puertas`=0, `pending`=0.
